// File: rtl/add_round_key5.sv
// add_round_key5 - round-5 AddRoundKey stage.
//
// Buffers a 16-byte cipher state (byte-serial, column-major index 0..15),
// then raises round_complete to ask the upstream key expansion stage for
// its round key. Each key byte is XORed with the matching buffered state
// byte and streamed out one cycle later.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   din_state      state byte in, qualified by enable_state
//   enable_state   din_state valid this cycle
//   state_ready    high while state bytes are being accepted
//   din_key        round-key byte from the key stage
//   enable_key     din_key valid
//   round_complete key request to the key stage
//   dout           state XOR key result byte
//   enable_out     dout valid
//   busy           high whenever state bytes are not being accepted
module add_round_key5 #(
  parameter int REQ_HOLD = 3,
  parameter int NB       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din_state,
  input  logic       enable_state,
  output logic       state_ready,
  input  logic [7:0] din_key,
  input  logic       enable_key,
  output logic       round_complete,
  output logic [7:0] dout,
  output logic       enable_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    LOAD_STATE,
    REQ_KEY,
    LOAD_KEY,
    FLUSH
  } state_t;

  localparam int            HW       = $clog2(REQ_HOLD + 1);
  localparam logic [4:0]    LAST_IDX = 5'(NB - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(REQ_HOLD);

  state_t        state;
  state_t        state_next;
  logic [7:0]    sbuf [NB];
  logic [4:0]    sidx;
  logic [4:0]    kidx;
  logic [HW-1:0] hold_cnt;
  logic          state_take;
  logic          key_take;

  // A byte is only taken when the FSM is in a phase that wants it, so
  // simultaneous state and key strobes can never both be accepted.
  assign state_take = (state == LOAD_STATE) && enable_state;
  assign key_take   = ((state == REQ_KEY) || (state == LOAD_KEY)) && enable_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_STATE;
    end else begin
      state <= state_next;
    end
  end

  // round_complete keeps requesting through the early part of LOAD_KEY
  // until the hold counter saturates, so an early first key byte cannot
  // shorten the request below REQ_HOLD cycles. Being decoded from the
  // state register, it drops as soon as rst clears the state.
  always_comb begin
    state_next     = state;
    state_ready    = 1'b0;
    busy           = 1'b1;
    round_complete = 1'b0;
    case (state)
      LOAD_STATE: begin
        state_ready = 1'b1;
        busy        = 1'b0;
        if (state_take && (sidx == LAST_IDX)) begin
          state_next = REQ_KEY;
        end
      end
      REQ_KEY: begin
        round_complete = 1'b1;
        if (key_take) begin
          state_next = LOAD_KEY;
        end
      end
      LOAD_KEY: begin
        round_complete = (hold_cnt < HOLD_MAX);
        if (key_take && (kidx == LAST_IDX)) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        state_next = LOAD_STATE;
      end
      default: begin
        state_next = LOAD_STATE;
      end
    endcase
  end

  // The state buffer needs no reset; its contents only matter after a
  // full block has been written.
  always_ff @(posedge clk) begin
    if (state_take) begin
      sbuf[sidx[3:0]] <= din_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sidx       <= '0;
      kidx       <= '0;
      hold_cnt   <= '0;
      dout       <= 8'h00;
      enable_out <= 1'b0;
    end else begin
      enable_out <= 1'b0;
      case (state)
        LOAD_STATE: begin
          if (state_take) begin
            sidx <= sidx + 5'd1;
          end
        end
        REQ_KEY, LOAD_KEY: begin
          if (hold_cnt < HOLD_MAX) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
          if (key_take) begin
            dout       <= sbuf[kidx[3:0]] ^ din_key;
            enable_out <= 1'b1;
            kidx       <= kidx + 5'd1;
          end
        end
        FLUSH: begin
          sidx     <= '0;
          kidx     <= '0;
          hold_cnt <= '0;
        end
        default: begin
          sidx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_round_key5.sv
// tb_add_round_key5 - directed self-checking bench for add_round_key5.
// Inputs change 1 time unit after the rising edge; a monitor samples the
// outputs on the falling edge and records every valid result byte.
module tb_add_round_key5;

  typedef logic [7:0] blk_t [16];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din_state;
  logic       enable_state;
  logic       state_ready;
  logic [7:0] din_key;
  logic       enable_key;
  logic       round_complete;
  logic [7:0] dout;
  logic       enable_out;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int         cyc = 0;
  logic [7:0] out_q [$];
  int         out_cyc [$];
  int         rc_cycles = 0;
  int         rc_rises = 0;
  logic       rc_prev = 1'b0;

  add_round_key5 #(.REQ_HOLD(3), .NB(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .din_state      (din_state),
    .enable_state   (enable_state),
    .state_ready    (state_ready),
    .din_key        (din_key),
    .enable_key     (enable_key),
    .round_complete (round_complete),
    .dout           (dout),
    .enable_out     (enable_out),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Output monitor: collects result bytes and round_complete activity.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (enable_out) begin
      out_q.push_back(dout);
      out_cyc.push_back(cyc);
    end
    if (round_complete) rc_cycles = rc_cycles + 1;
    if (round_complete && !rc_prev) rc_rises = rc_rises + 1;
    rc_prev = round_complete;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    out_q.delete();
    out_cyc.delete();
    rc_cycles = 0;
    rc_rises  = 0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    enable_state = 1'b0;
    enable_key   = 1'b0;
    din_state    = 8'h00;
    din_key      = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    clear_mon();
  endtask

  task automatic load_state(input blk_t b, input int gap);
    for (int i = 0; i < 16; i++) begin
      enable_state = 1'b1;
      din_state    = b[i];
      tick();
      enable_state = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic send_key(input blk_t k, input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      enable_key = 1'b1;
      din_key    = k[i];
      tick();
      enable_key = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_rc(output bit ok);
    int n = 0;
    while (!round_complete && n < 40) begin
      tick();
      n++;
    end
    ok = round_complete;
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!state_ready && n < 40) begin
      tick();
      n++;
    end
    ok = state_ready;
  endtask

  task automatic test_reset();
    blk_t s;
    do_reset();
    rst = 1'b1;
    #2;
    checks++; if (state_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_state_ready: got %b expected 1", state_ready); end
    checks++; if (round_complete !== 1'b0) begin errors++; $display("[TB] FAIL reset_round_complete: got %b expected 0", round_complete); end
    checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout: got %h expected 00", dout); end
    checks++; if (enable_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_enable_out: got %b expected 0", enable_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    do_reset();
    for (int i = 0; i < 16; i++) s[i] = 8'(i);
    load_state(s, 0);
    checks++; if (round_complete !== 1'b1) begin errors++; $display("[TB] FAIL reset_rc_before: got %b expected 1", round_complete); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (round_complete !== 1'b0) begin errors++; $display("[TB] FAIL reset_rc_async_drop: got %b expected 0", round_complete); end
    do_reset();
  endtask

  task automatic test_basic();
    blk_t s, k;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 16; i++) begin s[i] = 8'(i); k[i] = 8'hA5; end
    load_state(s, 0);
    checks++; if (state_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_state_ready_low: got %b expected 0", state_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
    checks++; if (round_complete !== 1'b1) begin errors++; $display("[TB] FAIL basic_rc_high: got %b expected 1", round_complete); end
    checks++; if (out_q.size() !== 0) begin errors++; $display("[TB] FAIL basic_no_output_during_load: got %0d expected 0", out_q.size()); end
    repeat (3) tick();
    send_key(k, 0, 15, 0);
    repeat (3) tick();
    checks++; if (out_q.size() !== 16) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 16", out_q.size()); end
    if (out_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        exp = 8'(i) ^ 8'hA5;
        checks++; if (out_q[i] !== exp) begin errors++; $display("[TB] FAIL basic_byte%0d: got %h expected %h", i, out_q[i], exp); end
      end
      checks++; if (out_cyc[15] - out_cyc[0] !== 15) begin errors++; $display("[TB] FAIL basic_consecutive: got span %0d expected 15", out_cyc[15] - out_cyc[0]); end
    end
    checks++; if (rc_cycles < 3) begin errors++; $display("[TB] FAIL basic_rc_hold: got %0d expected >=3", rc_cycles); end
    checks++; if (state_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_after: got %b expected 1", state_ready); end
  endtask

  task automatic test_early_key();
    blk_t s, k;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 16; i++) begin s[i] = 8'h40 + 8'(i); k[i] = 8'h5A; end
    load_state(s, 0);
    tick();
    enable_key = 1'b1;
    din_key    = k[0];
    tick();
    enable_key = 1'b0;
    checks++; if (enable_out !== 1'b1) begin errors++; $display("[TB] FAIL early_first_valid: got %b expected 1", enable_out); end
    checks++; if (dout !== 8'h1A) begin errors++; $display("[TB] FAIL early_first_byte: got %h expected 1a", dout); end
    checks++; if (round_complete !== 1'b1) begin errors++; $display("[TB] FAIL early_rc_still_high: got %b expected 1", round_complete); end
    send_key(k, 1, 15, 0);
    repeat (3) tick();
    checks++; if (rc_cycles !== 3) begin errors++; $display("[TB] FAIL early_rc_cycles: got %0d expected 3", rc_cycles); end
    checks++; if (out_q.size() !== 16) begin errors++; $display("[TB] FAIL early_count: got %0d expected 16", out_q.size()); end
    if (out_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        exp = (8'h40 + 8'(i)) ^ 8'h5A;
        checks++; if (out_q[i] !== exp) begin errors++; $display("[TB] FAIL early_byte%0d: got %h expected %h", i, out_q[i], exp); end
      end
    end
  endtask

  task automatic test_gapped();
    blk_t s, k;
    do_reset();
    for (int i = 0; i < 16; i++) begin s[i] = 8'hFF; k[i] = 8'h0F; end
    load_state(s, 1);
    repeat (3) tick();
    send_key(k, 0, 15, 2);
    repeat (3) tick();
    checks++; if (out_q.size() !== 16) begin errors++; $display("[TB] FAIL gapped_count: got %0d expected 16", out_q.size()); end
    if (out_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (out_q[i] !== 8'hF0) begin errors++; $display("[TB] FAIL gapped_byte%0d: got %h expected f0", i, out_q[i]); end
      end
      for (int i = 1; i < 16; i++) begin
        checks++; if (out_cyc[i] - out_cyc[i-1] !== 3) begin errors++; $display("[TB] FAIL gapped_spacing%0d: got %0d expected 3", i, out_cyc[i] - out_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_ignored();
    blk_t k;
    do_reset();
    for (int i = 0; i < 16; i++) k[i] = 8'h10 + 8'(i);
    for (int i = 0; i < 16; i++) begin
      enable_state = 1'b1;
      din_state    = 8'(i);
      enable_key   = 1'b1;
      din_key      = 8'h11;
      tick();
      enable_state = 1'b0;
      if (i < 15) tick();
    end
    enable_key = 1'b0;
    checks++; if (out_q.size() !== 0) begin errors++; $display("[TB] FAIL ignored_key_in_load: got %0d outputs expected 0", out_q.size()); end
    enable_state = 1'b1;
    din_state    = 8'h22;
    repeat (3) tick();
    send_key(k, 0, 15, 0);
    enable_state = 1'b0;
    enable_key   = 1'b1;
    din_key      = 8'h77;
    repeat (3) tick();
    enable_key = 1'b0;
    repeat (2) tick();
    checks++; if (out_q.size() !== 16) begin errors++; $display("[TB] FAIL ignored_count: got %0d expected 16", out_q.size()); end
    if (out_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (out_q[i] !== 8'h10) begin errors++; $display("[TB] FAIL ignored_byte%0d: got %h expected 10", i, out_q[i]); end
      end
    end
    checks++; if (state_ready !== 1'b1) begin errors++; $display("[TB] FAIL ignored_ready: got %b expected 1", state_ready); end
  endtask

  task automatic test_reset_mid();
    blk_t s, k;
    bit ok;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 16; i++) begin s[i] = 8'hC0 + 8'(i); k[i] = 8'h33; end
    load_state(s, 0);
    repeat (3) tick();
    send_key(k, 0, 7, 0);
    checks++; if (enable_out !== 1'b1) begin errors++; $display("[TB] FAIL mid_valid_before: got %b expected 1", enable_out); end
    rst = 1'b1;
    #1;
    checks++; if (enable_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_enable_out: got %b expected 0", enable_out); end
    checks++; if (round_complete !== 1'b0) begin errors++; $display("[TB] FAIL mid_round_complete: got %b expected 0", round_complete); end
    checks++; if (state_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_state_ready: got %b expected 1", state_ready); end
    tick();
    rst = 1'b0;
    tick();
    clear_mon();
    for (int i = 0; i < 16; i++) begin s[i] = 8'h30 + 8'(i); k[i] = 8'h00; end
    load_state(s, 0);
    wait_rc(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL mid_wait_rc: got %b expected 1", ok); end
    repeat (3) tick();
    send_key(k, 0, 15, 0);
    repeat (3) tick();
    checks++; if (out_q.size() !== 16) begin errors++; $display("[TB] FAIL mid_count: got %0d expected 16", out_q.size()); end
    if (out_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        exp = 8'h30 + 8'(i);
        checks++; if (out_q[i] !== exp) begin errors++; $display("[TB] FAIL mid_byte%0d: got %h expected %h", i, out_q[i], exp); end
      end
    end
  endtask

  task automatic test_back_to_back();
    blk_t sa, ka, sb, kb;
    bit ok;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      sa[i] = 8'(i);
      ka[i] = 8'hFF;
      sb[i] = 8'h80 + 8'(i);
      kb[i] = 8'h01;
    end
    load_state(sa, 0);
    repeat (3) tick();
    send_key(ka, 0, 15, 0);
    checks++; if (rc_rises !== 1) begin errors++; $display("[TB] FAIL b2b_rc_rises_first: got %0d expected 1", rc_rises); end
    wait_ready(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_wait_ready: got %b expected 1", ok); end
    load_state(sb, 0);
    wait_rc(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_wait_rc: got %b expected 1", ok); end
    repeat (3) tick();
    send_key(kb, 0, 15, 0);
    repeat (3) tick();
    checks++; if (rc_rises !== 2) begin errors++; $display("[TB] FAIL b2b_rc_rises_total: got %0d expected 2", rc_rises); end
    checks++; if (out_q.size() !== 32) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 32", out_q.size()); end
    if (out_q.size() == 32) begin
      for (int i = 0; i < 16; i++) begin
        exp = 8'(i) ^ 8'hFF;
        checks++; if (out_q[i] !== exp) begin errors++; $display("[TB] FAIL b2b_a_byte%0d: got %h expected %h", i, out_q[i], exp); end
        exp = (8'h80 + 8'(i)) ^ 8'h01;
        checks++; if (out_q[16+i] !== exp) begin errors++; $display("[TB] FAIL b2b_b_byte%0d: got %h expected %h", i, out_q[16+i], exp); end
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    enable_state = 1'b0;
    enable_key   = 1'b0;
    din_state    = 8'h00;
    din_key      = 8'h00;
    test_reset();
    test_basic();
    test_early_key();
    test_gapped();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_round_key5.md
Name: add_round_key5

Overview:
- Round-5 AddRoundKey stage, directly downstream of the round-5 key expansion stage.
- Buffers the 16-byte cipher state, byte-serial, index 0..15 column-major. Then asserts round_complete so the key expansion stage releases its round key.
- XORs each incoming key byte with the buffered state byte and streams the 16 result bytes to the next round.

Parameters:
- REQ_HOLD, 3: minimum number of cycles round_complete stays high once asserted. The key stage needs ≥3 consecutive high cycles.
- NB, 16: bytes per block. Only 16 is supported; counters are 5 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high. Clears all state immediately.
- din_state  input  8  state byte in.
- enable_state  input  1  din_state valid this cycle.
- state_ready  output  1  high while the block accepts state bytes (LOAD_STATE).
- din_key  input  8  round-key byte, driven by the key stage dout.
- enable_key  input  1  din_key valid, driven by the key stage enable_out.
- round_complete  output  1  key request to the key stage.
- dout  output  8  state XOR key result byte.
- enable_out  output  1  dout valid.
- busy  output  1  high in every state except LOAD_STATE.

Behaviour:
- Reset values:
  - outputs: state_ready=1, round_complete=0, dout=0x00, enable_out=0, busy=0.
  - internal: state=LOAD_STATE, sidx=0, kidx=0, hold counter=0.
  - State buffer contents are don't-care.
- FSM: LOAD_STATE -> REQ_KEY -> LOAD_KEY -> FLUSH -> LOAD_STATE.
- LOAD_STATE:
  - Each cycle with enable_state=1: sbuf[sidx]<=din_state, sidx++.
  - On capture of byte 15, next state is REQ_KEY; state_ready falls the following cycle.
  - Gaps in enable_state are allowed.
  - enable_key in this state is ignored; no output is produced.
- REQ_KEY:
  - round_complete=1 from the first REQ_KEY cycle.
  - hold counter increments each cycle, saturating at REQ_HOLD.
  - Key bytes are accepted here; acceptance follows the LOAD_KEY rule.
- round_complete deassertion:
  - Falls the cycle after the first key byte is captured AND the hold counter has reached REQ_HOLD.
  - If the first key byte arrives early, round_complete stays high until REQ_HOLD is satisfied.
  - It never drops before REQ_HOLD cycles.
- Transition to LOAD_KEY happens on the first key byte.
- LOAD_KEY:
  - Each cycle with enable_key=1: dout<=sbuf[kidx]^din_key, enable_out<=1, kidx++.
  - Cycles with enable_key=0: enable_out<=0, dout holds its value.
  - Latency: key byte at edge t appears on dout at t+1. Gapless input gives exactly 16 consecutive enable_out cycles.
  - After key byte 15 is captured, next state is FLUSH.
- FLUSH (one cycle):
  - enable_out<=0; sidx, kidx and hold counter clear to 0.
  - Return to LOAD_STATE; state_ready rises.
- Boundary rules:
  - enable_state while busy: ignored, no buffer corruption.
  - enable_key beyond the 16th byte (FLUSH/LOAD_STATE): ignored.
  - enable_state and enable_key in the same cycle: each is judged independently against the current state, so at most one is accepted.
  - Counters never wrap past 15; the state transition occurs at the byte-15 capture.
  - rst asserted mid-block (any state): immediate return to reset values. A partially received block is discarded. round_complete drops asynchronously.
- Arithmetic: pure 8-bit XOR, no carries. Output byte order equals key byte order 0..15.

Test Plan:
- Basic: state bytes 0x00..0x0F gapless, then after ≥3 cycles of round_complete, key bytes all 0xA5 gapless -> dout = i^0xA5 (0xA5,0xA4,...,0xAA) over 16 consecutive enable_out cycles, starting the cycle after the first key byte. round_complete high ≥3 cycles.
- Early key: first key byte the cycle after round_complete rises -> round_complete still high for exactly 3 cycles; first result byte sbuf[0]^key0 one cycle after capture.
- Gapped streams: state bytes every other cycle, key bytes with 2-cycle gaps, state=0xFF, key=0x0F -> 16 outputs, all 0xF0. enable_out low in the gap cycles, no extra or missing bytes.
- Ignored traffic: key bytes 0x11 during LOAD_STATE and state bytes 0x22 during LOAD_KEY -> no output, buffer unaffected; results match a clean run with state 0x00..0x0F and key 0x10..0x1F (all 0x10).
- Reset mid-operation: assert rst after key byte 7 -> enable_out=0, round_complete=0 and state_ready=1 immediately. A following full block with state 0x30..0x3F and key 0x00 outputs 0x30..0x3F.
- Back-to-back: two blocks, the second loaded while state_ready is high after FLUSH -> second block's round_complete asserted exactly once; both 16-byte results correct, with no overlap of enable_out between blocks.
